inst_mem_server: RTL and testbench



---
 rtl/inst_mem_server.sv | 147 ++++++++++++++
 tb/tb_inst_mem_server.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_server.sv
// inst_mem_server: fixed-latency instruction-memory server for the Blimp fetch port.
// Each accepted request yields one in-order response p_latency cycles later.
// A credit-limited response FIFO absorbs back-pressure on resp_rdy.
// Optional feature macro: INST_MEM_WRITE_EN enables byte-masked writes to the array.
// Without it the array is read-only, but write requests are still accepted and answered.
// rst is asynchronous and active-low.
module inst_mem_server #(
    parameter int unsigned p_addr_bits   = 32,
    parameter int unsigned p_data_bits   = 32,
    parameter int unsigned p_opaque_bits = 8,
    parameter int unsigned p_mem_words   = 256,
    parameter int unsigned p_latency     = 2,
    parameter int unsigned p_resp_depth  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_val,
    output logic                     req_rdy,
    input  logic                     req_op,
    input  logic [p_addr_bits-1:0]   req_addr,
    input  logic [p_data_bits-1:0]   req_data,
    input  logic [p_data_bits/8-1:0] req_strb,
    input  logic [p_opaque_bits-1:0] req_opaque,
    output logic                     resp_val,
    input  logic                     resp_rdy,
    output logic                     resp_op,
    output logic [p_data_bits-1:0]   resp_data,
    output logic [p_opaque_bits-1:0] resp_opaque
);

    localparam int unsigned IDX_W = $clog2(p_mem_words);
    localparam int unsigned NB    = p_data_bits / 8;
    localparam int unsigned ENT_W = 1 + p_data_bits + p_opaque_bits;
    localparam int unsigned NSTG  = (p_latency > 1) ? p_latency - 1 : 1;
    localparam int unsigned PTR_W = (p_resp_depth > 1) ? $clog2(p_resp_depth) : 1;
    localparam int unsigned CNT_W = $clog2(p_resp_depth + 1);

    // Storage array; deliberately not reset.
    logic [p_data_bits-1:0] mem [p_mem_words];

    logic [IDX_W-1:0]       idx;
    logic                   acc;
    logic                   deq;
    logic [p_data_bits-1:0] rd_word;
    logic [ENT_W-1:0]       entry_in;
    logic                   enq;
    logic [ENT_W-1:0]       enq_ent;

    logic [ENT_W-1:0]       fifo_q [p_resp_depth];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       inflight_q;
    logic [CNT_W-1:0]       inflight_nxt;
    logic [ENT_W-1:0]       head_ent;

    // Word index ignores the byte offset; upper bits wrap by truncation.
    assign idx      = req_addr[IDX_W+1:2];
    assign acc      = req_val & req_rdy;
    assign deq      = resp_val & resp_rdy;
    assign rd_word  = req_op ? '0 : mem[idx];
    assign entry_in = {req_op, rd_word, req_opaque};

    // Backdoor loader for simulation; the array has no reset or load port.
    task automatic init_word(input int unsigned i, input logic [p_data_bits-1:0] d);
        mem[IDX_W'(i)] = d;
    endtask

`ifdef INST_MEM_WRITE_EN
    // Byte-masked write at the accept edge; plain always so the backdoor loader may share the array.
    always @(posedge clk) begin
        if (acc && req_op) begin
            for (int b = 0; b < NB; b++) begin
                if (req_strb[b]) mem[idx][8*b +: 8] <= req_data[8*b +: 8];
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_addr[p_addr_bits-1:IDX_W+2]};
`else
    logic unused_bits;
    assign unused_bits = ^{req_addr[1:0], req_addr[p_addr_bits-1:IDX_W+2], req_data, req_strb};
`endif

    // Read-data pipeline of p_latency-1 stages ahead of the FIFO.
    if (p_latency > 1) begin : g_pipe
        logic [NSTG-1:0]  pv_q;
        logic [ENT_W-1:0] pd_q [NSTG];

        // Stage valid bits, cleared by reset.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv_q <= '0;
            end else begin
                pv_q[0] <= acc;
                for (int s = 1; s < NSTG; s++) pv_q[s] <= pv_q[s-1];
            end
        end

        // Stage payloads; qualified by the valid bits, so no reset.
        always_ff @(posedge clk) begin
            if (acc) pd_q[0] <= entry_in;
            for (int s = 1; s < NSTG; s++) pd_q[s] <= pd_q[s-1];
        end

        assign enq     = pv_q[NSTG-1];
        assign enq_ent = pd_q[NSTG-1];
    end else begin : g_nopipe
        assign enq     = acc;
        assign enq_ent = entry_in;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(p_resp_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign inflight_nxt = inflight_q + CNT_W'(acc) - CNT_W'(deq);

    // FIFO pointers, occupancy, credit counter and registered req_rdy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            req_rdy    <= 1'b1;
        end else begin
            if (enq) tail_q <= ptr_inc(tail_q);
            if (deq) head_q <= ptr_inc(head_q);
            cnt_q      <= cnt_q + CNT_W'(enq) - CNT_W'(deq);
            inflight_q <= inflight_nxt;
            req_rdy    <= (inflight_nxt < CNT_W'(p_resp_depth));
        end
    end

    // FIFO entry storage; occupancy tracks which entries are live.
    always_ff @(posedge clk) begin
        if (enq) fifo_q[tail_q] <= enq_ent;
    end

    // Response comes straight from the head entry, forced to zero when empty.
    assign head_ent = fifo_q[head_q];
    assign resp_val = (cnt_q != '0);
    assign {resp_op, resp_data, resp_opaque} = resp_val ? head_ent : '0;

endmodule

// File: tb/tb_inst_mem_server.sv
// Directed, table-driven bench for inst_mem_server (default parameters).
module tb_inst_mem_server;

    logic        clk;
    logic        rst;
    logic        req_val;
    logic        req_rdy;
    logic        req_op;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic [7:0]  req_opaque;
    logic        resp_val;
    logic        resp_rdy;
    logic        resp_op;
    logic [31:0] resp_data;
    logic [7:0]  resp_opaque;

    int tests = 0;
    int fails = 0;

    inst_mem_server dut (
        .clk         (clk),
        .rst         (rst),
        .req_val     (req_val),
        .req_rdy     (req_rdy),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_strb    (req_strb),
        .req_opaque  (req_opaque),
        .resp_val    (resp_val),
        .resp_rdy    (resp_rdy),
        .resp_op     (resp_op),
        .resp_data   (resp_data),
        .resp_opaque (resp_opaque)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [7:0]  opq;
        logic [31:0] exp_data;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] rq_d [$];
    int          rq_c [$];
    int          k_at_stall;
    logic        rdy_at_stall;
    logic        rdy_after;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following acceptance with req_val dropped.
    task automatic issue_req(input logic op, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] opq);
        int n = 0;
        req_val = 1'b1; req_op = op; req_addr = addr; req_data = data;
        req_strb = strb; req_opaque = opq;
        while (!req_rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_rdy_wait", 64'(req_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
    endtask

    // Called at a negedge with resp_rdy=1; returns at the negedge after the response was taken.
    task automatic get_resp(output logic op, output logic [31:0] d, output logic [7:0] o, output bit ok);
        ok = 1'b0; op = 1'b0; d = '0; o = '0;
        for (int n = 0; n < 20; n++) begin
            if (resp_val) begin
                op = resp_op; d = resp_data; o = resp_opaque; ok = 1'b1;
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    // Cycle-stepped burst of n reads from word base upward; resp_rdy held low for the first stall cycles.
    task automatic run_seq(input int n, input int stall, input int base);
        int k = 0;
        bit pend = 1'b0;
        rq_d.delete();
        rq_c.delete();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pend) k++;
            resp_rdy = (c >= stall);
            if (c == stall) begin
                k_at_stall   = k;
                rdy_at_stall = req_rdy;
            end
            if (c == stall + 1) rdy_after = req_rdy;
            if (resp_val && resp_rdy) begin
                rq_d.push_back(resp_data);
                rq_c.push_back(c);
            end
            req_val    = (k < n);
            req_op     = 1'b0;
            req_addr   = 32'((base + k) * 4);
            req_opaque = 8'(k);
            pend       = req_val && req_rdy;
        end
        req_val  = 1'b0;
        resp_rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r_op;
        logic [31:0] r_d;
        logic [7:0]  r_o;
        bit          ok;
        logic [31:0] exp_b2b [4];
        logic [31:0] exp_stall [6];
        logic [31:0] exp_raw;

        rst = 1'b0; req_val = 1'b0; req_op = 1'b0; req_addr = '0; req_data = '0;
        req_strb = '0; req_opaque = '0; resp_rdy = 1'b1;

        dut.init_word(0,   32'h11111111);
        dut.init_word(1,   32'h22222222);
        dut.init_word(2,   32'h33333333);
        dut.init_word(3,   32'h44444444);
        dut.init_word(4,   32'hDEADBEEF);
        dut.init_word(5,   32'h55555555);
        dut.init_word(8,   32'hFFFFFFFF);
        dut.init_word(9,   32'h12345678);
        dut.init_word(255, 32'hA5A5A5A5);

        exp_b2b   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        exp_stall = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                      32'hDEADBEEF, 32'h55555555};
`ifdef INST_MEM_WRITE_EN
        exp_raw = 32'hFFFFF00D;
`else
        exp_raw = 32'hFFFFFFFF;
`endif

        vecs[0] = '{1'b0, 32'h00000010, 32'h0,         4'h0, 8'h01, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 32'h00000400, 32'h0,         4'h0, 8'h02, 32'h11111111};
        vecs[2] = '{1'b0, 32'h000003FC, 32'h0,         4'h0, 8'h03, 32'hA5A5A5A5};
        vecs[3] = '{1'b0, 32'h00000013, 32'h0,         4'h0, 8'h04, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 32'hFFFFF004, 32'h0,         4'h0, 8'h05, 32'h22222222};
        vecs[5] = '{1'b1, 32'h00000024, 32'hAABBCCDD, 4'hC, 8'h06, 32'h00000000};
`ifdef INST_MEM_WRITE_EN
        vecs[6] = '{1'b0, 32'h00000024, 32'h0,         4'h0, 8'h07, 32'hAABB5678};
`else
        vecs[6] = '{1'b0, 32'h00000024, 32'h0,         4'h0, 8'h07, 32'h12345678};
`endif

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp_val",    64'(resp_val),    64'd0);
        chk("rst_req_rdy",     64'(req_rdy),     64'd1);
        chk("rst_resp_op",     64'(resp_op),     64'd0);
        chk("rst_resp_data",   64'(resp_data),   64'd0);
        chk("rst_resp_opaque", 64'(resp_opaque), 64'd0);
        rst = 1'b1;

        // Exact latency of a single read, issued right after reset release
        chk("lat_rdy", 64'(req_rdy), 64'd1);
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 8'h5A);
        chk("lat_early", 64'(resp_val), 64'd0);
        @(negedge clk);
        chk("lat_val",  64'(resp_val),    64'd1);
        chk("lat_data", 64'(resp_data),   64'hDEADBEEF);
        chk("lat_opq",  64'(resp_opaque), 64'h5A);
        chk("lat_op",   64'(resp_op),     64'd0);
        @(negedge clk);
        chk("lat_drain", 64'(resp_val), 64'd0);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            issue_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].opq);
            get_resp(r_op, r_d, r_o, ok);
            chk($sformatf("vec%0d_ok", i),   64'(ok),   64'd1);
            chk($sformatf("vec%0d_data", i), 64'(r_d),  64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_opq", i),  64'(r_o),  64'(vecs[i].opq));
            chk($sformatf("vec%0d_op", i),   64'(r_op), 64'(vecs[i].op));
        end

        // Back-to-back reads: one response per cycle, first at cycle 2
        run_seq(4, 0, 0);
        chk("b2b_count", 64'(rq_d.size()), 64'd4);
        for (int i = 0; i < 4 && i < rq_d.size(); i++) begin
            chk($sformatf("b2b_data%0d", i), 64'(rq_d[i]), 64'(exp_b2b[i]));
            chk($sformatf("b2b_cyc%0d", i),  64'(rq_c[i]), 64'(2 + i));
        end

        // Full stall: four accepts then req_rdy low; reopens one cycle after first dequeue
        run_seq(6, 8, 0);
        chk("stall_accepts", 64'(k_at_stall),   64'd4);
        chk("stall_rdy_low", 64'(rdy_at_stall), 64'd0);
        chk("stall_rdy_up",  64'(rdy_after),    64'd1);
        chk("stall_count",   64'(rq_d.size()),  64'd6);
        for (int i = 0; i < 6 && i < rq_d.size(); i++)
            chk($sformatf("stall_data%0d", i), 64'(rq_d[i]), 64'(exp_stall[i]));

        // Write with partial strobe followed immediately by a read of the same word
        @(negedge clk);
        chk("raw_rdy", 64'(req_rdy), 64'd1);
        req_val = 1'b1; req_op = 1'b1; req_addr = 32'h20; req_data = 32'hCAFEF00D;
        req_strb = 4'b0011; req_opaque = 8'h77;
        @(posedge clk);
        @(negedge clk);
        req_op = 1'b0; req_opaque = 8'h78; req_strb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        req_val = 1'b0;
        get_resp(r_op, r_d, r_o, ok);
        chk("raw_wr_ok",   64'(ok),   64'd1);
        chk("raw_wr_op",   64'(r_op), 64'd1);
        chk("raw_wr_data", 64'(r_d),  64'd0);
        chk("raw_wr_opq",  64'(r_o),  64'h77);
        get_resp(r_op, r_d, r_o, ok);
        chk("raw_rd_ok",   64'(ok),   64'd1);
        chk("raw_rd_data", 64'(r_d),  64'(exp_raw));
        chk("raw_rd_opq",  64'(r_o),  64'h78);

        // Reset with three responses pending
        resp_rdy = 1'b0;
        issue_req(1'b0, 32'h0, 32'h0, 4'h0, 8'hA0);
        issue_req(1'b0, 32'h4, 32'h0, 4'h0, 8'hA1);
        issue_req(1'b0, 32'h8, 32'h0, 4'h0, 8'hA2);
        @(negedge clk);
        chk("mid_pending", 64'(resp_val), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_val",  64'(resp_val),  64'd0);
        chk("mid_rst_rdy",  64'(req_rdy),   64'd1);
        chk("mid_rst_data", 64'(resp_data), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        resp_rdy = 1'b1;
        chk("post_rst_val", 64'(resp_val), 64'd0);
        issue_req(1'b0, 32'h10, 32'h0, 4'h0, 8'hC3);
        get_resp(r_op, r_d, r_o, ok);
        chk("post_rst_ok",   64'(ok),  64'd1);
        chk("post_rst_data", 64'(r_d), 64'hDEADBEEF);
        chk("post_rst_opq",  64'(r_o), 64'hC3);
        @(negedge clk);
        chk("post_rst_idle", 64'(resp_val), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
